// File: rtl/instr_sequencer.sv
// instr_sequencer: Moore control FSM for a simple fetch/decode/execute CPU.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   opcode, op            : instruction register fields [15:13] and [12:11]
//   load_ir, load_pc,
//   reset_pc, addr_sel,
//   load_addr, mem_cmd    : fetch / program counter / memory controls
//   nsel, vsel, write,
//   loada, loadb, asel,
//   bsel, loadc, loads    : datapath controls
//   halted, state_dbg     : status (state codes numbered RST=0 .. HALT=17)
module instr_sequencer #(
  parameter logic [1:0] MNONE  = 2'b00,
  parameter logic [1:0] MREAD  = 2'b01,
  parameter logic [1:0] MWRITE = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       halted,
  output logic [4:0] state_dbg
);

  localparam logic [4:0] S_RST   = 5'd0;
  localparam logic [4:0] S_IF1   = 5'd1;
  localparam logic [4:0] S_IF2   = 5'd2;
  localparam logic [4:0] S_UPC   = 5'd3;
  localparam logic [4:0] S_DEC   = 5'd4;
  localparam logic [4:0] S_WIMM  = 5'd5;
  localparam logic [4:0] S_GETA  = 5'd6;
  localparam logic [4:0] S_GETB  = 5'd7;
  localparam logic [4:0] S_EXEC  = 5'd8;
  localparam logic [4:0] S_WREG  = 5'd9;
  localparam logic [4:0] S_ADDR  = 5'd10;
  localparam logic [4:0] S_LAD   = 5'd11;
  localparam logic [4:0] S_MRD   = 5'd12;
  localparam logic [4:0] S_MWB   = 5'd13;
  localparam logic [4:0] S_GETD  = 5'd14;
  localparam logic [4:0] S_PASSD = 5'd15;
  localparam logic [4:0] S_MWR   = 5'd16;
  localparam logic [4:0] S_HALT  = 5'd17;

  logic [4:0] state_q, state_d;
  logic       is_alu, is_cmp, pass_a, is_ldr;

  // Instruction class decode used by the branching states
  assign is_alu = (opcode == 3'b101);
  assign is_cmp = is_alu && (op == 2'b01);
  assign pass_a = (opcode == 3'b110 && op == 2'b00) || (is_alu && op == 2'b11);
  assign is_ldr = (opcode == 3'b011);

  // State register; reset wins from any state, including HALT
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Next state and Moore output decode
  always_comb begin
    state_d   = state_q;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MNONE;
    nsel      = 3'b000;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        state_d  = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MREAD;
        state_d  = S_IF2;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MREAD;
        load_ir  = 1'b1;
        state_d  = S_UPC;
      end
      S_UPC: begin
        load_pc = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        // Unrecognised encodings fall back to fetch as a NOP
        casez ({opcode, op})
          5'b11010: state_d = S_WIMM;
          5'b11000: state_d = S_GETB;
          5'b101??: state_d = S_GETA;
          5'b01100: state_d = S_GETA;
          5'b10000: state_d = S_GETA;
          5'b11100: state_d = S_HALT;
          default:  state_d = S_IF1;
        endcase
      end
      S_WIMM: begin
        nsel    = 3'b100;
        vsel    = 2'b10;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_GETA: begin
        nsel    = 3'b100;
        loada   = 1'b1;
        state_d = is_alu ? S_GETB : S_ADDR;
      end
      S_GETB: begin
        nsel    = 3'b001;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        loadc   = 1'b1;
        asel    = pass_a;
        loads   = is_cmp;
        state_d = is_cmp ? S_IF1 : S_WREG;
      end
      S_WREG: begin
        nsel    = 3'b010;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_ADDR: begin
        bsel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_LAD;
      end
      S_LAD: begin
        load_addr = 1'b1;
        state_d   = is_ldr ? S_MRD : S_GETD;
      end
      S_MRD: begin
        mem_cmd = MREAD;
        state_d = S_MWB;
      end
      S_MWB: begin
        mem_cmd = MREAD;
        nsel    = 3'b010;
        vsel    = 2'b11;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_GETD: begin
        nsel    = 3'b010;
        loadb   = 1'b1;
        state_d = S_PASSD;
      end
      S_PASSD: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_MWR;
      end
      S_MWR: begin
        mem_cmd = MWRITE;
        state_d = S_IF1;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter MNONE, default 2'b00, meaning the mem_cmd encoding for "no access".
REQ-002 SHALL have parameter MREAD, default 2'b01, meaning the mem_cmd encoding for a read.
REQ-003 SHALL have parameter MWRITE, default 2'b10, meaning the mem_cmd encoding for a write.
REQ-004 SHALL have port: clk  input  1  rising-edge clock; single clock domain.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: opcode  input  3  instruction register bits [15:13].
REQ-007 SHALL have port: op  input  2  instruction register bits [12:11].
REQ-008 SHALL have these outputs:
- load_ir, load_pc, reset_pc, addr_sel, load_addr: output 1 each; IR load, PC load, PC clear, address mux select (1=PC, 0=data address), data-address register load.
- mem_cmd: output 2.
- nsel: output 3; one-hot register select, 100=Rn, 010=Rd, 001=Rm.
- vsel: output 2; writeback source, 00=C, 01=PC, 10=sximm8, 11=mdata.
- write, loada, loadb, asel, bsel, loadc, loads: output 1 each; datapath controls.
- halted: output 1; high in HALT.
- state_dbg: output 5; current state code.

Function
REQ-009 SHALL be a Moore FSM: registered state, outputs decoded from state plus opcode/op; every output not listed for a state is 0 and mem_cmd=MNONE.
REQ-010 SHALL implement states and outputs as follows:
- RST: reset_pc=1, load_pc=1; next IF1.
- IF1: addr_sel=1, mem_cmd=MREAD; next IF2.
- IF2: addr_sel=1, mem_cmd=MREAD, load_ir=1; next UPC.
- UPC: load_pc=1 (PC+1); next DEC.
REQ-011 SHALL decode in DEC from {opcode,op}:
- 11010 (MOV imm) -> WIMM.
- 11000 (MOV reg) -> GETB.
- 101xx (ALU) -> GETA.
- 01100 (LDR) -> GETA.
- 10000 (STR) -> GETA.
- 11100 (HALT) -> HALT.
- any other encoding -> IF1 (NOP; no register or memory side effects).
REQ-012 SHALL implement:
- WIMM: nsel=100, vsel=10, write=1; next IF1.
- GETA: nsel=100, loada=1; next GETB if ALU, else ADDR.
- GETB: nsel=001, loadb=1; next EXEC.
REQ-013 SHALL in EXEC assert loadc=1, bsel=0, and asel=1 for MOV reg or MVN (op=11), else 0; loads=1 only for CMP (101,01); next IF1 for CMP, else WREG.
REQ-014 SHALL in WREG assert nsel=010, vsel=00, write=1; next IF1.
REQ-015 SHALL implement the memory states:
- ADDR: asel=0, bsel=1, loadc=1; next LAD.
- LAD: load_addr=1, addr_sel=0; next MRD (LDR) or GETD (STR).
- MRD: addr_sel=0, mem_cmd=MREAD; next MWB.
- MWB: addr_sel=0, mem_cmd=MREAD, nsel=010, vsel=11, write=1; next IF1.
- GETD: nsel=010, loadb=1; next PASSD.
- PASSD: asel=1, bsel=0, loadc=1; next MWR.
- MWR: addr_sel=0, mem_cmd=MWRITE; next IF1.
REQ-016 SHALL hold HALT indefinitely with halted=1, load_pc=0, and mem_cmd=MNONE until reset.
REQ-017 SHALL sample opcode/op only in DEC and in states that branch on them; IR is stable because load_ir is asserted only in IF2.
REQ-018 SHALL never assert write and mem_cmd=MWRITE in the same cycle, nor load_pc outside RST and UPC.

Reset
REQ-019 SHALL, when reset=1 at a rising edge, enter RST regardless of current state, including mid-instruction and HALT.
REQ-020 SHALL remain in RST while reset is held, and SHALL enter IF1 on the first edge after deassertion.
REQ-021 SHALL produce the RST output set (reset_pc=1, load_pc=1, all else 0) for every cycle spent in RST.

Verification
REQ-022 SHALL pass reset: hold reset 3 cycles, release -> state RST for 1 cycle, then IF1; reset_pc=1 only in RST.
REQ-023 SHALL pass MOV imm: {110,10} -> IF1,IF2,UPC,DEC,WIMM, back to IF1 after 5 cycles; write=1 with vsel=10, nsel=100 in exactly 1 cycle.
REQ-024 SHALL pass LDR: {011,00} -> 9-cycle sequence ending in MWB with mem_cmd=01, vsel=11, write=1; load_addr=1 in exactly 1 cycle.
REQ-025 SHALL pass STR: {100,00} -> 10-cycle sequence; mem_cmd=10 in exactly 1 cycle (MWR) with addr_sel=0; write never 1.
REQ-026 SHALL pass CMP: {101,01} -> IF1..EXEC in 7 cycles; loads=1 once; write never 1.
REQ-027 SHALL pass HALT: {111,00} -> HALT with halted=1 and no load_pc for 20 cycles; reset=1 -> RST next cycle.
